// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcodes, error bit
// positions and the sequencer FSM state encoding.
package alu_pkg;

  localparam int DATA_W = 16;   // operand width
  localparam int RES_W  = 32;   // ALU result width
  localparam int OP_W   = 4;    // opcode width
  localparam int ERR_W  = 2;    // ALU error flag width
  localparam int CNT_W  = 4;    // settle counter width (covers 1..15)

  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_MUL = 4'd3;
  localparam logic [OP_W-1:0] OP_DIV = 4'd4;
  localparam logic [OP_W-1:0] OP_MOD = 4'd5;

  localparam int ERR_OVF  = 0;  // add/sub overflow
  localparam int ERR_DIVZ = 1;  // div/mod by zero

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Only ADD..MOD are executed by the ALU; everything else short-circuits.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_MOD);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of the command, ALU and response signals of the sequencer.
// slave  = sequencer side, master = environment (command source, ALU,
// response sink).
interface alu_sequencer_if;
  import alu_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [OP_W-1:0]     cmd_op;
  logic [DATA_W-1:0]   cmd_a;
  logic [DATA_W-1:0]   cmd_b;

  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [OP_W-1:0]     alu_op;
  logic [RES_W-1:0]    alu_c;
  logic [ERR_W-1:0]    alu_err;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [RES_W-1:0]    rsp_c;
  logic [ERR_W-1:0]    rsp_err;
  logic                rsp_illegal;

  logic [ERR_W-1:0]    err_sticky;
  logic                clr_sticky;
  logic [15:0]         op_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_c, alu_err,
    output rsp_valid, rsp_c, rsp_err, rsp_illegal,
    input  rsp_ready,
    output err_sticky, op_count,
    input  clr_sticky
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_c, alu_err,
    input  rsp_valid, rsp_c, rsp_err, rsp_illegal,
    output rsp_ready,
    input  err_sticky, op_count,
    output clr_sticky
  );

endinterface

// File: rtl/alu_settle_timer.sv
// Loadable down-counter; o_done is high while the count is zero.
module alu_settle_timer
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // Load has priority; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer that hands one command at a time to an external combinational
// ALU, waits SETTLE_CYCLES edges, captures the result and offers it on a
// valid/ready response port. Illegal opcodes bypass the ALU entirely.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
)(
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);

  // The timer is loaded with N-1 so that capture happens on the N-th edge
  // after accept (the accept edge itself is the load).
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_next;

  logic               w_cmd_ready;
  logic               w_accept;
  logic               w_legal;
  logic               w_rsp_hs;
  logic               w_capture;
  logic               w_timer_done;

  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [OP_W-1:0]    r_alu_op;
  logic [RES_W-1:0]   r_rsp_c;
  logic [ERR_W-1:0]   r_rsp_err;
  logic               r_rsp_illegal;
  logic [ERR_W-1:0]   r_err_sticky;
  logic [15:0]        r_op_count;

  // Ready while idle, or while a response is being consumed this edge.
  assign w_cmd_ready = (r_state == ST_IDLE) ||
                       ((r_state == ST_RESP) && bus.rsp_ready);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_legal     = is_legal_op(bus.cmd_op);
  assign w_rsp_hs    = (r_state == ST_RESP) && bus.rsp_ready;
  assign w_capture   = (r_state == ST_SETTLE) && w_timer_done;

  alu_settle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept && w_legal),
    .i_load_val (SETTLE_LOAD),
    .i_en       (r_state == ST_SETTLE),
    .o_done     (w_timer_done)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: accepts from IDLE or from RESP during a handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_legal ? ST_SETTLE : ST_RESP;
        end
      end
      ST_SETTLE: begin
        if (w_timer_done) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_rsp_hs) begin
          if (w_accept) begin
            w_state_next = w_legal ? ST_SETTLE : ST_RESP;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ALU operand/opcode registers: loaded only on a legal accept, else held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else if (w_accept && w_legal) begin
      r_alu_a  <= bus.cmd_a;
      r_alu_b  <= bus.cmd_b;
      r_alu_op <= bus.cmd_op;
    end
  end

  // Response fields: ALU capture at settle end, or an immediate illegal
  // response; otherwise held so they stay stable under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_c       <= '0;
      r_rsp_err     <= '0;
      r_rsp_illegal <= 1'b0;
    end else if (w_capture) begin
      r_rsp_c       <= bus.alu_c;
      r_rsp_err     <= bus.alu_err;
      r_rsp_illegal <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_rsp_c       <= '0;
      r_rsp_err     <= '0;
      r_rsp_illegal <= 1'b1;
    end
  end

  // Sticky error accumulator; a clear on the capture edge keeps only the
  // newly captured error bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sticky <= '0;
    end else if (w_capture) begin
      r_err_sticky <= (bus.clr_sticky ? '0 : r_err_sticky) | bus.alu_err;
    end else if (bus.clr_sticky) begin
      r_err_sticky <= '0;
    end
  end

  // Completed-response counter, saturating at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_rsp_hs && (r_op_count != 16'hFFFF)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_op      = r_alu_op;
  assign bus.rsp_valid   = (r_state == ST_RESP);
  assign bus.rsp_c       = r_rsp_c;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_illegal = r_rsp_illegal;
  assign bus.err_sticky  = r_err_sticky;
  assign bus.op_count    = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU breadboard.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  alu_sequencer_if bus_if();

  alu_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU breadboard: signed 16-bit add/sub/div/mod sign-extended, 32-bit mul.
  logic signed [15:0] bb_a, bb_b, bb_r16;
  always_comb begin
    bb_a           = $signed(bus_if.alu_a);
    bb_b           = $signed(bus_if.alu_b);
    bb_r16         = '0;
    bus_if.alu_c   = '0;
    bus_if.alu_err = 2'b00;
    case (bus_if.alu_op)
      OP_ADD: begin
        bb_r16 = bb_a + bb_b;
        bus_if.alu_c = {{16{bb_r16[15]}}, bb_r16};
        bus_if.alu_err[ERR_OVF] = (bb_a[15] == bb_b[15]) && (bb_r16[15] != bb_a[15]);
      end
      OP_SUB: begin
        bb_r16 = bb_a - bb_b;
        bus_if.alu_c = {{16{bb_r16[15]}}, bb_r16};
        bus_if.alu_err[ERR_OVF] = (bb_a[15] != bb_b[15]) && (bb_r16[15] != bb_a[15]);
      end
      OP_MUL: begin
        bus_if.alu_c = 32'($signed({{16{bb_a[15]}}, bb_a}) * $signed({{16{bb_b[15]}}, bb_b}));
      end
      OP_DIV, OP_MOD: begin
        if (bb_b == 16'sd0) begin
          bus_if.alu_err[ERR_DIVZ] = 1'b1;
        end else begin
          bb_r16 = (bus_if.alu_op == OP_DIV) ? (bb_a / bb_b) : (bb_a % bb_b);
          bus_if.alu_c = {{16{bb_r16[15]}}, bb_r16};
        end
      end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_a     = a;
    bus_if.cmd_b     = b;
  endtask

  task automatic test_reset();
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_op     = '0;
    bus_if.cmd_a      = '0;
    bus_if.cmd_b      = '0;
    bus_if.rsp_ready  = 1'b0;
    bus_if.clr_sticky = 1'b0;
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if (bus_if.rsp_valid !== 1'b0 || bus_if.rsp_c !== 32'h0 || bus_if.rsp_err !== 2'b00 ||
        bus_if.rsp_illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rsp: valid=%b c=%h err=%b ill=%b, required 0/0/00/0",
               bus_if.rsp_valid, bus_if.rsp_c, bus_if.rsp_err, bus_if.rsp_illegal);
    end
    tests_run++;
    if (bus_if.alu_a !== 16'h0 || bus_if.alu_b !== 16'h0 || bus_if.alu_op !== 4'h0 ||
        bus_if.err_sticky !== 2'b00 || bus_if.op_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: a=%h b=%h op=%h sticky=%b cnt=%0d, required all zero",
               bus_if.alu_a, bus_if.alu_b, bus_if.alu_op, bus_if.err_sticky, bus_if.op_count);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus_if.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_cmd_ready: got %b required 1", bus_if.cmd_ready);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_add();
    bus_if.rsp_ready = 1'b1;
    drive_cmd(OP_ADD, 16'd4, 16'd2);
    step();                            // accept edge
    bus_if.cmd_valid = 1'b0;
    tests_run++;
    if (bus_if.rsp_valid !== 1'b0 || bus_if.alu_a !== 16'd4 || bus_if.alu_b !== 16'd2) begin
      tests_failed++;
      $display("FAIL add_load: valid=%b a=%h b=%h, required 0/4/2",
               bus_if.rsp_valid, bus_if.alu_a, bus_if.alu_b);
    end
    step();                            // edge 1
    tests_run++;
    if (bus_if.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_early: rsp_valid=%b after 1 edge, required 0", bus_if.rsp_valid);
    end
    step();                            // edge 2 = capture
    tests_run++;
    if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_c !== 32'h6 || bus_if.rsp_err !== 2'b00 ||
        bus_if.rsp_illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_rsp: valid=%b c=%h err=%b ill=%b, required 1/00000006/00/0",
               bus_if.rsp_valid, bus_if.rsp_c, bus_if.rsp_err, bus_if.rsp_illegal);
    end
    step();                            // handshake
    tests_run++;
    if (bus_if.op_count !== 16'd1 || bus_if.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_count: cnt=%0d valid=%b, required 1/0", bus_if.op_count, bus_if.rsp_valid);
    end
    $display("[TB] ADD 4+2 -> c=%h", bus_if.rsp_c);
  endtask

  task automatic test_sticky();
    bus_if.rsp_ready = 1'b1;
    drive_cmd(OP_ADD, 16'h7000, 16'h2000);
    step();
    bus_if.cmd_valid = 1'b0;
    step();
    step();
    tests_run++;
    if (bus_if.rsp_c !== 32'hFFFF9000 || bus_if.rsp_err !== 2'b01 || bus_if.err_sticky !== 2'b01) begin
      tests_failed++;
      $display("FAIL ovf_add: c=%h err=%b sticky=%b, required FFFF9000/01/01",
               bus_if.rsp_c, bus_if.rsp_err, bus_if.err_sticky);
    end
    step();
    drive_cmd(OP_DIV, 16'd7, 16'd0);
    step();
    bus_if.cmd_valid = 1'b0;
    step();
    step();
    tests_run++;
    if (bus_if.rsp_err !== 2'b10 || bus_if.err_sticky !== 2'b11) begin
      tests_failed++;
      $display("FAIL div_zero: err=%b sticky=%b, required 10/11", bus_if.rsp_err, bus_if.err_sticky);
    end
    step();
    // Clear coincident with capture keeps only the new error.
    drive_cmd(OP_SUB, 16'h8000, 16'h0001);
    step();
    bus_if.cmd_valid = 1'b0;
    step();
    bus_if.clr_sticky = 1'b1;
    step();
    bus_if.clr_sticky = 1'b0;
    tests_run++;
    if (bus_if.rsp_c !== 32'h00007FFF || bus_if.rsp_err !== 2'b01 || bus_if.err_sticky !== 2'b01) begin
      tests_failed++;
      $display("FAIL clr_at_capture: c=%h err=%b sticky=%b, required 00007FFF/01/01",
               bus_if.rsp_c, bus_if.rsp_err, bus_if.err_sticky);
    end
    step();
    bus_if.clr_sticky = 1'b1;
    step();
    bus_if.clr_sticky = 1'b0;
    tests_run++;
    if (bus_if.err_sticky !== 2'b00 || bus_if.op_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL clr_pulse: sticky=%b cnt=%0d, required 00/4", bus_if.err_sticky, bus_if.op_count);
    end
    $display("[TB] sticky sequence sticky=%b count=%0d", bus_if.err_sticky, bus_if.op_count);
  endtask

  task automatic test_back_to_back();
    bus_if.rsp_ready = 1'b0;
    drive_cmd(OP_MUL, 16'd7, 16'd2);
    step();
    bus_if.cmd_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      // Offer a command that must be ignored while back-pressured.
      drive_cmd(OP_ADD, 16'(i + 100), 16'd3);
      #1;
      tests_run++;
      if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_c !== 32'd14 || bus_if.cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_%0d: valid=%b c=%h ready=%b, required 1/0000000e/0",
                 i, bus_if.rsp_valid, bus_if.rsp_c, bus_if.cmd_ready);
      end
      step();
    end
    tests_run++;
    if (bus_if.alu_a !== 16'd7 || bus_if.alu_op !== OP_MUL) begin
      tests_failed++;
      $display("FAIL ignore_cmd: alu_a=%h alu_op=%h, required 7/3", bus_if.alu_a, bus_if.alu_op);
    end
    drive_cmd(OP_MOD, 16'd7, 16'd2);
    bus_if.rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (bus_if.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready: got %b required 1", bus_if.cmd_ready);
    end
    step();                            // handshake + accept on same edge
    bus_if.cmd_valid = 1'b0;
    tests_run++;
    if (bus_if.rsp_valid !== 1'b0 || bus_if.alu_op !== OP_MOD || bus_if.op_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL b2b_accept: valid=%b alu_op=%h cnt=%0d, required 0/5/5",
               bus_if.rsp_valid, bus_if.alu_op, bus_if.op_count);
    end
    step();
    step();
    tests_run++;
    if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_c !== 32'd1) begin
      tests_failed++;
      $display("FAIL b2b_mod: valid=%b c=%h, required 1/00000001", bus_if.rsp_valid, bus_if.rsp_c);
    end
    step();
    $display("[TB] MUL hold then MOD back-to-back c=%h", bus_if.rsp_c);
  endtask

  task automatic test_illegal();
    bus_if.rsp_ready = 1'b1;
    drive_cmd(4'd9, 16'd3, 16'd3);
    step();
    bus_if.cmd_valid = 1'b0;
    tests_run++;
    if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_illegal !== 1'b1 || bus_if.rsp_c !== 32'h0 ||
        bus_if.rsp_err !== 2'b00) begin
      tests_failed++;
      $display("FAIL illegal_rsp: valid=%b ill=%b c=%h err=%b, required 1/1/0/00",
               bus_if.rsp_valid, bus_if.rsp_illegal, bus_if.rsp_c, bus_if.rsp_err);
    end
    tests_run++;
    if (bus_if.alu_op !== OP_MOD || bus_if.alu_a !== 16'd7 || bus_if.alu_b !== 16'd2) begin
      tests_failed++;
      $display("FAIL illegal_alu: op=%h a=%h b=%h, required 5/7/2",
               bus_if.alu_op, bus_if.alu_a, bus_if.alu_b);
    end
    step();
    tests_run++;
    if (bus_if.op_count !== 16'd7 || bus_if.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_done: cnt=%0d valid=%b, required 7/0", bus_if.op_count, bus_if.rsp_valid);
    end
    $display("[TB] illegal op 9 ill=1 count=%0d", bus_if.op_count);
  endtask

  task automatic test_reset_midflight();
    int seen;
    bus_if.rsp_ready = 1'b1;
    drive_cmd(OP_SUB, 16'd9, 16'd4);
    step();
    bus_if.cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus_if.rsp_valid !== 1'b0 || bus_if.alu_a !== 16'h0 || bus_if.alu_op !== 4'h0 ||
        bus_if.op_count !== 16'h0 || bus_if.err_sticky !== 2'b00 || bus_if.rsp_c !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_async: valid=%b a=%h op=%h cnt=%0d sticky=%b c=%h, required all zero",
               bus_if.rsp_valid, bus_if.alu_a, bus_if.alu_op, bus_if.op_count,
               bus_if.err_sticky, bus_if.rsp_c);
    end
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus_if.rsp_valid !== 1'b0) seen++;
      step();
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL rst_discard: rsp_valid seen %0d cycles, required 0", seen);
    end
    drive_cmd(OP_ADD, 16'd1, 16'd1);
    step();
    bus_if.cmd_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && bus_if.rsp_valid !== 1'b1; i++) begin
      step();
      seen++;
    end
    tests_run++;
    if (bus_if.rsp_valid !== 1'b1 || seen != 2 || bus_if.rsp_c !== 32'd2) begin
      tests_failed++;
      $display("FAIL post_rst_add: valid=%b edges=%0d c=%h, required 1/2/00000002",
               bus_if.rsp_valid, seen, bus_if.rsp_c);
    end
    step();
    $display("[TB] reset mid-flight then ADD 1+1 -> c=%h", bus_if.rsp_c);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    test_reset();
    test_add();
    test_sticky();
    test_back_to_back();
    test_illegal();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
